// File: rtl/pio_bidir_pkg.sv
// Shared constants for the bidirectional PIO: register word offsets and capture-edge encodings.
package pio_bidir_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA = 3'd0,
        ADDR_DIR  = 3'd1,
        ADDR_MASK = 3'd2,
        ADDR_EDGE = 3'd3,
        ADDR_SET  = 3'd4,
        ADDR_CLR  = 3'd5
    } pio_addr_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_bidir_irq_if.sv
// Avalon-MM slave bus bundle for pio_bidir_irq (address/strobes/data).
interface pio_bidir_irq_if #(
    parameter int unsigned WIDTH = 8
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_sync_edge.sv
// Pad input synchroniser plus one delayed copy for per-bit edge detection.
module pio_sync_edge
    import pio_bidir_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     d_prev_q;
    logic [SYNC_STAGES:0] prime_q;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
    logic [WIDTH-1:0]     sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            d_prev_q <= '0;
            prime_q  <= '0;
        end else begin
            sync_q[0] <= pad_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            d_prev_q <= sync_q[SYNC_STAGES-1];
            prime_q  <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];

    // The zero reset value of the chain is not a real pin level; suppress edges
    // until d_prev holds a sampled pad value so pulled-up pins don't capture at boot.
    always_comb begin
        rise = data_in & ~d_prev_q;
        fall = ~data_in & d_prev_q;
        case (EDGE_TYPE)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            default:   sel = rise | fall;
        endcase
        edge_pulse = prime_q[SYNC_STAGES] ? sel : '0;
    end

endmodule

// File: rtl/pio_bidir_irq.sv
// Avalon-MM bidirectional PIO with edge capture, maskable irq and atomic set/clear.
// Build option: PIO_OPEN_DRAIN_EN selects open-drain pad drive instead of push-pull.
module pio_bidir_irq
    import pio_bidir_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 2,
    parameter logic [31:0] RESET_OUT   = 32'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    pio_bidir_irq_if.slave      bus,
    inout  wire  [WIDTH-1:0]    bidir_port,
    output logic                irq
);

    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_dir_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_cap_q;
    logic [WIDTH-1:0] readdata_q;
    logic [WIDTH-1:0] readdata_d;
    logic             irq_q;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_clr;
    logic             wr_en;

    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign edge_clr = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata : '0;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .pad_in     (bidir_port),
        .data_in    (data_in),
        .edge_pulse (edge_pulse)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_OUT[WIDTH-1:0];
            data_dir_q <= '0;
            irq_mask_q <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA: data_out_q <= bus.writedata;
                ADDR_DIR:  data_dir_q <= bus.writedata;
                ADDR_MASK: irq_mask_q <= bus.writedata;
                ADDR_SET:  data_out_q <= data_out_q | bus.writedata;
                ADDR_CLR:  data_out_q <= data_out_q & ~bus.writedata;
                default:   ;
            endcase
        end
    end

    // A detected edge beats a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_q <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            edge_cap_q <= (edge_cap_q & ~edge_clr) | edge_pulse;
            irq_q      <= |(edge_cap_q & irq_mask_q);
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA: readdata_d = data_in;
            ADDR_DIR:  readdata_d = data_dir_q;
            ADDR_MASK: readdata_d = irq_mask_q;
            ADDR_EDGE: readdata_d = edge_cap_q;
            default:   readdata_d = '0;
        endcase
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pad
`ifdef PIO_OPEN_DRAIN_EN
        assign bidir_port[i] = (data_dir_q[i] && !data_out_q[i]) ? 1'b0 : 1'bz;
`else
        assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
`endif
    end

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Directed self-checking bench for pio_bidir_irq (8 pins, 2 sync stages, rising-edge capture).
module tb_pio_bidir_irq;
    import pio_bidir_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         irq;
    wire  [W-1:0] pads;
    logic [W-1:0] tb_oe = '0;
    logic [W-1:0] tb_val = '0;
    int           checks = 0;
    int           failures = 0;

    pio_bidir_irq_if #(.WIDTH(W)) bus ();

    always #5 clk = ~clk;

    for (genvar i = 0; i < int'(W); i++) begin : g_pad
        pullup (pads[i]);
        assign pads[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    pio_bidir_irq #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (0),
        .RESET_OUT   (32'h0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .bidir_port (pads),
        .irq        (irq)
    );

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [W-1:0] d);
        bus.address = a;
        @(posedge clk); #1;
        d = bus.readdata;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        #1;
        checks++;
        if (bus.readdata !== 8'h00) begin failures++; $display("FAIL rst_readdata got=%h exp=00", bus.readdata); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
        checks++;
        if (pads !== 8'hFF) begin failures++; $display("FAIL rst_pads got=%h exp=ff", pads); end
        @(posedge clk); #1; reset_n = 1'b1;
        idle(4);
        rd(ADDR_DATA, d);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL rst_data got=%h exp=ff", d); end
        rd(ADDR_DIR, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL rst_dir got=%h exp=00", d); end
        rd(ADDR_MASK, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL rst_mask got=%h exp=00", d); end
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL rst_edge got=%h exp=00", d); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq2 got=%b exp=0", irq); end
    endtask

    task automatic test_output();
        logic [W-1:0] d;
        wr(ADDR_DIR, 8'h0F);
        wr(ADDR_DATA, 8'hA5);
        checks++;
        if (pads !== 8'hF5) begin failures++; $display("FAIL out_pads got=%h exp=f5", pads); end
        wr(ADDR_SET, 8'h02);
        wr(ADDR_CLR, 8'h01);
        checks++;
        if (pads !== 8'hF6) begin failures++; $display("FAIL setclr_pads got=%h exp=f6", pads); end
        idle(4);
        rd(ADDR_DATA, d);
        checks++;
        if (d !== 8'hF6) begin failures++; $display("FAIL setclr_data got=%h exp=f6", d); end
        rd(ADDR_DIR, d);
        checks++;
        if (d !== 8'h0F) begin failures++; $display("FAIL dir_rb got=%h exp=0f", d); end
        // Output pins are read back: rises on bits 0 (DATA), 2 (DATA), 1 (OUTSET).
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h07) begin failures++; $display("FAIL out_edge got=%h exp=07", d); end
    endtask

    task automatic test_edge_irq();
        logic [W-1:0] d;
        wr(ADDR_MASK, 8'h10);
        tb_oe[4] = 1'b1; tb_val[4] = 1'b0;
        idle(4);
        wr(ADDR_EDGE, 8'hFF);
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL edge_clr0 got=%h exp=00", d); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_pre got=%b exp=0", irq); end
        tb_val[4] = 1'b1;
        idle(3);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
        idle(1);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
        checks++;
        if (bus.readdata !== 8'h10) begin failures++; $display("FAIL edge_cap got=%h exp=10", bus.readdata); end
        wr(ADDR_EDGE, 8'h10);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq); end
        idle(1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
    endtask

    task automatic test_mask_off();
        logic [W-1:0] d;
        tb_val[4] = 1'b0;
        idle(4);
        wr(ADDR_EDGE, 8'hFF);
        tb_val[4] = 1'b1;
        idle(5);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL mask_irq_on got=%b exp=1", irq); end
        wr(ADDR_MASK, 8'h00);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL mask_irq_hold got=%b exp=1", irq); end
        idle(1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq_off got=%b exp=0", irq); end
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h10) begin failures++; $display("FAIL mask_edge_kept got=%h exp=10", d); end
        wr(ADDR_MASK, 8'h10);
        wr(ADDR_EDGE, 8'hFF);
        tb_oe[4] = 1'b0;
        idle(1);
    endtask

    task automatic test_set_wins();
        logic [W-1:0] d;
        wr(ADDR_DIR, 8'h00);
        tb_oe[2] = 1'b1; tb_val[2] = 1'b0;
        idle(4);
        wr(ADDR_EDGE, 8'hFF);
        tb_val[2] = 1'b1;
        idle(2);
        wr(ADDR_EDGE, 8'h04);
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h04) begin failures++; $display("FAIL set_wins got=%h exp=04", d); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL unmasked_irq got=%b exp=0", irq); end
        wr(ADDR_EDGE, 8'h04);
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL w1c_bit2 got=%h exp=00", d); end
        tb_oe[2] = 1'b0;
        idle(1);
    endtask

    task automatic test_glitch();
        logic [W-1:0] d;
        tb_oe[0] = 1'b1; tb_val[0] = 1'b0;
        idle(4);
        wr(ADDR_EDGE, 8'hFF);
        tb_val[0] = 1'b1;
        #2;
        tb_val[0] = 1'b0;
        @(posedge clk); #1;
        idle(4);
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL glitch_edge got=%h exp=00", d); end
        rd(ADDR_DATA, d);
        checks++;
        if (d !== 8'hFE) begin failures++; $display("FAIL glitch_data got=%h exp=fe", d); end
        tb_oe[0] = 1'b0;
        idle(4);
        wr(ADDR_EDGE, 8'hFF);
    endtask

    task automatic test_reserved();
        logic [W-1:0] d;
        wr(3'd6, 8'hFF);
        wr(3'd7, 8'hFF);
        rd(3'd6, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL rsv6 got=%h exp=00", d); end
        rd(3'd7, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL rsv7 got=%h exp=00", d); end
        rd(ADDR_SET, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL outset_rd got=%h exp=00", d); end
        rd(ADDR_CLR, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL outclr_rd got=%h exp=00", d); end
        rd(ADDR_MASK, d);
        checks++;
        if (d !== 8'h10) begin failures++; $display("FAIL no_alias_mask got=%h exp=10", d); end
        rd(ADDR_DIR, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL no_alias_dir got=%h exp=00", d); end
        rd(ADDR_EDGE, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL no_alias_edge got=%h exp=00", d); end
    endtask

`ifdef PIO_OPEN_DRAIN_EN
    task automatic test_open_drain();
        logic [W-1:0] d;
        wr(ADDR_DIR, 8'h01);
        wr(ADDR_DATA, 8'h01);
        checks++;
        if (pads[0] !== 1'b1) begin failures++; $display("FAIL od_high got=%b exp=1", pads[0]); end
        wr(ADDR_DATA, 8'h00);
        checks++;
        if (pads[0] !== 1'b0) begin failures++; $display("FAIL od_low got=%b exp=0", pads[0]); end
        idle(4);
        rd(ADDR_DATA, d);
        checks++;
        if (d !== 8'hFE) begin failures++; $display("FAIL od_data got=%h exp=fe", d); end
        rd(ADDR_DIR, d);
        checks++;
        if (d !== 8'h01) begin failures++; $display("FAIL od_dir got=%h exp=01", d); end
    endtask
`endif

    initial begin
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        test_reset();
        test_output();
        test_edge_irq();
        test_mask_off();
        test_set_wins();
        test_glitch();
        test_reserved();
`ifdef PIO_OPEN_DRAIN_EN
        test_open_drain();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/pio_bidir_irq.md
Name: pio_bidir_irq

Overview:
Parametrised Avalon-MM bidirectional PIO, the successor to the single-bit bit-banged SDA PIO.
- WIDTH pins, each with its own direction bit.
- Input synchronisation, per-bit edge capture, maskable level interrupt.
- Atomic bit-set/bit-clear output registers, so firmware can bit-bang I2C/SPI lines without read-modify-write races.
- Sits on the Nios system bus next to the I/O-expander and sensor interfaces.

Parameters:
- WIDTH, 8, number of bidirectional pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- EDGE_TYPE, 2, capture edge: 0 rising, 1 falling, 2 any.
- RESET_OUT, 0, reset value of data_out register (WIDTH bits, zero-extended).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  registered read data.
- bidir_port  inout  WIDTH  pads.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset: asynchronous, active-low, on reset_n; clock is clk.
- Register map (word offsets):
  - 0 DATA: read = synchronised pin value; write = data_out.
  - 1 DIR: 1 = output.
  - 2 IRQ_MASK.
  - 3 EDGE_CAP: read; write-1-to-clear.
  - 4 OUTSET: write 1s OR into data_out; reads 0.
  - 5 OUTCLR: write 1s clear data_out bits; reads 0.
  - 6–7: reserved, read 0, writes ignored.
- Reset values:
  - readdata = 0, data_out = RESET_OUT, data_dir = 0 (all inputs).
  - irq_mask = 0, edge_cap = 0, irq = 0.
  - Synchroniser flops = 0.
- Writes take effect on the clk edge where chipselect & ~write_n.
- Read: readdata is registered every cycle from the address mux, regardless of chipselect. Data is valid 1 cycle after the address is presented.
- Pad drive: bit i driven with data_out[i] when data_dir[i] = 1, else Z.
- Input path:
  - data_in = pad value through SYNC_STAGES flops.
  - One extra delayed copy (d_prev) is kept for edge detection.
  - A pin change is visible at DATA read SYNC_STAGES+1 cycles after the pad edge (SYNC_STAGES flops + readdata register).
- Edge detect on synchronised data:
  - rise = data_in & ~d_prev; fall = ~data_in & d_prev.
  - Selected per EDGE_TYPE.
- edge_cap[i] sets on a detected edge and holds until cleared.
  - If a detect and a W1C on the same bit occur in the same cycle, set wins.
- Edge capture operates on output pins too: the pad is read back.
- irq = |(edge_cap & irq_mask), registered, so it asserts 1 cycle after edge_cap sets.
  - Deasserts 1 cycle after the last masked bit clears, or after its mask bit is written to 0.
- Pins driven from reset are never released mid-operation; reset asynchronously tri-states all pins.
- writedata bits above WIDTH do not exist; WIDTH is exact. Undefined address bits are decoded fully (no aliasing).

Optional Feature:
Macro PIO_OPEN_DRAIN_EN.
- Defined: the pad is driven 0 only when data_dir[i] = 1 and data_out[i] = 0; otherwise Z, so external pull-up yields 1. This is the I2C-safe mode. DIR is still readable/writable.
- Undefined: push-pull as described above.

Decomposition:
- Package pio_bidir_pkg:
  - Register offset constants: ADDR_DATA, ADDR_DIR, ADDR_MASK, ADDR_EDGE, ADDR_SET, ADDR_CLR.
  - Edge-type encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module pio_sync_edge:
  - Parameters WIDTH, SYNC_STAGES, EDGE_TYPE.
  - Inputs: raw pad vector.
  - Outputs: synchronised data and a 1-cycle edge pulse vector.
  - Instantiated once in pio_bidir_irq.

Test Plan:
1. Reset then read all offsets -> DATA equals the pad pull values, DIR = 0x00, MASK = 0x00, EDGE = 0x00, irq = 0, all pads Z.
2. Write DIR = 0x0F, DATA = 0xA5 -> pads[3:0] = 0x5 next cycle, pads[7:4] = Z. OUTSET 0x02 then OUTCLR 0x01 -> DATA readback low nibble = 0x6.
3. EDGE_TYPE = 0, MASK = 0x10: drive pad[4] 0 -> 1 -> EDGE reads 0x10, irq high SYNC_STAGES+2 cycles after the pad edge. Write EDGE = 0x10 -> irq low 1 cycle later.
4. Edge on bit 2 in the same cycle as a W1C to bit 2 -> EDGE bit 2 remains 1. Edge on bit 2 with MASK bit 2 = 0 -> irq stays 0.
5. Glitch on pad[0] shorter than 1 clk between edges -> no metastable X on readdata; at most one capture.
6. With PIO_OPEN_DRAIN_EN, DIR = 0x01, DATA = 0x01 -> pad[0] = Z (reads 1 via pull-up). DATA = 0x00 -> pad[0] = 0.
